// File: rtl/ps2_mouse_rx_pkg.sv
// ps2_mouse_rx_pkg
//   Shared PS/2 constants and the receive frame FSM state encoding.
//   Also used by the host transmitter (ps2_tx), so keep the values stable.
package ps2_mouse_rx_pkg;

  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
//   Device-to-host PS/2 frame receiver: synchronises ps2clk/ps2data, shifts in
//   start/8 data/parity/stop on ps2clk falling edges and checks odd parity and
//   the stop bit. A per-bit watchdog aborts a stalled frame.
// Ports
//   clk, reset      system clock, async active-low reset
//   ps2clk, ps2data PS/2 bus pins (read only)
//   rx_en           0 forces the receiver idle with no pulses
//   rx_byte         last good byte
//   rx_byte_valid   1-cycle pulse, rx_byte updated
//   frame_err       1-cycle pulse, parity/stop/timeout error
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data=0 on a falling edge)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and parity, then back to idle
module ps2_rx_frame
  import ps2_mouse_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic       rx_en,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err
);

  localparam int              TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   T_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;   // only the second stage is consumed, aligned with clk_sync[1]
  logic          fe;
  logic          bit_in;
  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2clk};
      data_sync <= {data_sync[0], ps2data};
    end
  end

  assign fe     = ~clk_sync[1] & clk_sync[2];
  assign bit_in = data_sync[1];

  // Watchdog is a down-counter reloaded on every falling edge; it only runs
  // while a frame is open, and a falling edge always wins over expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      par           <= 1'b0;
      tmr           <= T_LOAD;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
      if (!rx_en) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        tmr     <= T_LOAD;
      end else if (fe) begin
        tmr <= T_LOAD;
        case (state)
          ST_IDLE: begin
            if (!bit_in) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= bit_in;
            state <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (bit_in && (^{shreg, par})) begin
              rx_byte       <= shreg;
              rx_byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (tmr == '0) begin
          state     <= ST_IDLE;
          tmr       <= T_LOAD;
          frame_err <= 1'b1;
        end else begin
          tmr <= tmr - TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx
//   PS/2 mouse receive path: waits for the 0xFA acknowledge of the enable
//   command, then assembles 3-byte stream packets into buttons and signed
//   9-bit dx/dy. Listens only; rx_en=0 while the host transmitter owns the bus.
// Ports
//   clk, reset            system clock, async active-low reset
//   ps2clk, ps2data       PS/2 bus pins (read only)
//   rx_en                 1 = receive, 0 = idle and disarm
//   rx_byte/rx_byte_valid last good byte and its 1-cycle pulse
//   frame_err             1-cycle pulse on parity/stop/timeout error
//   ack                   1-cycle pulse: 0xFA seen while not armed
//   pkt_valid             1-cycle pulse: btn/dx/dy/x_ovf/y_ovf updated
//   btn                   {middle,right,left}
//   dx, dy                two's complement movement
//   x_ovf, y_ovf          overflow flags from byte 0
module ps2_mouse_rx
  import ps2_mouse_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic       rx_en,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic       ack,
  output logic       pkt_valid,
  output logic [2:0] btn,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       x_ovf,
  output logic       y_ovf
);

  logic       armed;
  logic [1:0] idx;
  logic [7:0] b0;
  logic [7:0] bx;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk          (clk),
    .reset        (reset),
    .ps2clk       (ps2clk),
    .ps2data      (ps2data),
    .rx_en        (rx_en),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_err    (frame_err)
  );

  // rx_en low disarms and discards any byte arriving in the same cycle.
  // Byte 0 always has bit 3 set; a byte without it cannot start a packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed     <= 1'b0;
      idx       <= '0;
      b0        <= '0;
      bx        <= '0;
      ack       <= 1'b0;
      pkt_valid <= 1'b0;
      btn       <= '0;
      dx        <= '0;
      dy        <= '0;
      x_ovf     <= 1'b0;
      y_ovf     <= 1'b0;
    end else begin
      ack       <= 1'b0;
      pkt_valid <= 1'b0;
      if (!rx_en) begin
        armed <= 1'b0;
        idx   <= '0;
      end else if (frame_err) begin
        idx <= '0;
      end else if (rx_byte_valid) begin
        if (!armed) begin
          if (rx_byte == PS2_ACK) begin
            ack   <= 1'b1;
            armed <= 1'b1;
          end
        end else begin
          case (idx)
            2'd0: begin
              if (rx_byte[3]) begin
                b0  <= rx_byte;
                idx <= 2'd1;
              end
            end
            2'd1: begin
              bx  <= rx_byte;
              idx <= 2'd2;
            end
            default: begin
              btn       <= b0[2:0];
              dx        <= {b0[4], bx};
              dy        <= {b0[5], rx_byte};
              x_ovf     <= b0[6];
              y_ovf     <= b0[7];
              pkt_valid <= 1'b1;
              idx       <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
`timescale 1ns/1ps
module tb_ps2_mouse_rx;

  // Device timing scaled 1/100 (80 clk bit period) with a matching timeout.
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic       rx_en = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_byte_valid, frame_err, ack, pkt_valid;
  logic [2:0] btn;
  logic [8:0] dx, dy;
  logic       x_ovf, y_ovf;

  always #5 clk = ~clk;

  ps2_mouse_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data), .rx_en(rx_en),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .frame_err(frame_err),
    .ack(ack), .pkt_valid(pkt_valid), .btn(btn), .dx(dx), .dy(dy),
    .x_ovf(x_ovf), .y_ovf(y_ovf)
  );

  typedef enum int {EV_BYTE, EV_ERR, EV_ACK, EV_PKT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    logic [2:0] btn;
    logic [8:0] dx, dy;
    logic       xo, yo;
  } ev_t;
  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [2:0] btn;
    logic [8:0] dx, dy;
    logic       xo, yo;
  } vec_t;

  ev_t        exp_q[$];
  vec_t       vecs[5];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         byte_cyc = -10;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(ev_kind_t k, logic [7:0] d, logic [2:0] b,
                                logic [8:0] x, logic [8:0] y, logic xo, logic yo);
    ev_t e;
    e.kind = k; e.data = d; e.btn = b; e.dx = x; e.dy = y; e.xo = xo; e.yo = yo;
    return e;
  endfunction

  task automatic pop_exp(input string name, output ev_t e, output bit ok);
    e = mk_ev(EV_BYTE, 8'h00, 3'd0, 9'd0, 9'd0, 1'b0, 1'b0);
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got a pulse, expected none", name);
    end else begin
      e = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    chk({"pending_", name}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Device model: data set 20 clk before the falling edge, 40 low, 40 high.
  task automatic send_frame(input logic [7:0] b, input logic par_bad,
                            input logic stop_val, input int nbits, input int gap);
    logic [10:0] f;
    logic        p;
    p = ~(^b);
    if (par_bad) p = ~p;
    f = {stop_val, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2data = f[i];
      #200 ps2clk = 1'b0;
      #400 ps2clk = 1'b1;
      #200;
    end
    ps2data = 1'b1;
    #(gap);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(mk_ev(EV_BYTE, b, 3'd0, 9'd0, 9'd0, 1'b0, 1'b0));
    last_good = b;
    send_frame(b, 1'b0, 1'b1, 11, 1000);
  endtask

  task automatic send_ack();
    exp_q.push_back(mk_ev(EV_BYTE, 8'hFA, 3'd0, 9'd0, 9'd0, 1'b0, 1'b0));
    exp_q.push_back(mk_ev(EV_ACK, 8'hFA, 3'd0, 9'd0, 9'd0, 1'b0, 1'b0));
    last_good = 8'hFA;
    send_frame(8'hFA, 1'b0, 1'b1, 11, 1000);
  endtask

  task automatic push_err();
    exp_q.push_back(mk_ev(EV_ERR, last_good, 3'd0, 9'd0, 9'd0, 1'b0, 1'b0));
  endtask

  task automatic send_pkt(input vec_t v);
    exp_q.push_back(mk_ev(EV_BYTE, v.b0, 3'd0, 9'd0, 9'd0, 1'b0, 1'b0));
    exp_q.push_back(mk_ev(EV_BYTE, v.b1, 3'd0, 9'd0, 9'd0, 1'b0, 1'b0));
    exp_q.push_back(mk_ev(EV_BYTE, v.b2, 3'd0, 9'd0, 9'd0, 1'b0, 1'b0));
    exp_q.push_back(mk_ev(EV_PKT, v.b2, v.btn, v.dx, v.dy, v.xo, v.yo));
    last_good = v.b2;
    send_frame(v.b0, 1'b0, 1'b1, 11, 1000);
    send_frame(v.b1, 1'b0, 1'b1, 11, 1000);
    send_frame(v.b2, 1'b0, 1'b1, 11, 1000);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_rx_byte"}, rx_byte, 0);
    chk({name, "_pulses"}, {rx_byte_valid, frame_err, ack, pkt_valid}, 0);
    chk({name, "_btn"}, btn, 0);
    chk({name, "_dx"}, dx, 0);
    chk({name, "_dy"}, dy, 0);
    chk({name, "_ovf"}, {x_ovf, y_ovf}, 0);
  endtask

  initial begin
    //                b0     b1     b2     btn     dx       dy       xo    yo
    vecs[0] = '{8'h09, 8'h05, 8'hFB, 3'b001, 9'h005, 9'h0FB, 1'b0, 1'b0};
    vecs[1] = '{8'hF8, 8'hFF, 8'h80, 3'b000, 9'h1FF, 9'h180, 1'b1, 1'b1};
    vecs[2] = '{8'h08, 8'h01, 8'h02, 3'b000, 9'h001, 9'h002, 1'b0, 1'b0};
    vecs[3] = '{8'h2B, 8'h10, 8'hFF, 3'b011, 9'h010, 9'h1FF, 1'b0, 1'b0};
    vecs[4] = '{8'hFA, 8'h80, 8'h7F, 3'b010, 9'h180, 9'h17F, 1'b1, 1'b1};

    fork
      forever begin
        ev_t e;
        bit  ok;
        @(negedge clk);
        cyc++;
        if (reset) begin
          if (rx_byte_valid) begin
            pop_exp("byte", e, ok);
            if (ok) begin
              chk("byte_kind", int'(EV_BYTE), int'(e.kind));
              chk("rx_byte", rx_byte, e.data);
            end
            byte_cyc = cyc;
          end
          if (frame_err) begin
            pop_exp("frame_err", e, ok);
            if (ok) begin
              chk("err_kind", int'(EV_ERR), int'(e.kind));
              chk("err_rx_byte_hold", rx_byte, e.data);
            end
          end
          if (ack) begin
            pop_exp("ack", e, ok);
            if (ok) begin
              chk("ack_kind", int'(EV_ACK), int'(e.kind));
              chk("ack_latency", cyc - byte_cyc, 1);
            end
          end
          if (pkt_valid) begin
            pop_exp("pkt_valid", e, ok);
            if (ok) begin
              chk("pkt_kind", int'(EV_PKT), int'(e.kind));
              chk("pkt_latency", cyc - byte_cyc, 1);
              chk("btn", btn, e.btn);
              chk("dx", dx, e.dx);
              chk("dy", dy, e.dy);
              chk("x_ovf", x_ovf, e.xo);
              chk("y_ovf", y_ovf, e.yo);
            end
          end
        end
      end
    join_none

    #2 reset = 1'b0;
    rx_en = 1'b1;
    #21;
    check_all_zero("reset");
    #20 reset = 1'b1;
    #200;

    // Not armed: a non-ACK byte is only reported as a byte
    send_good(8'h09);
    drain("unarmed");
    send_ack();
    drain("ack");

    foreach (vecs[i]) begin
      send_pkt(vecs[i]);
      drain($sformatf("vec%0d", i));
    end

    // Bad parity, then bad stop bit
    push_err();
    send_frame(8'h3C, 1'b1, 1'b1, 11, 1000);
    drain("parity");
    push_err();
    send_frame(8'h3C, 1'b0, 1'b0, 11, 1000);
    drain("stop");

    // An error between packet bytes restarts the packet
    send_good(8'h09);
    push_err();
    send_frame(8'h55, 1'b1, 1'b1, 11, 1000);
    send_pkt(vecs[2]);
    drain("err_midpkt");

    // Timeout after data bit 4, then a full packet
    send_good(8'h09);
    push_err();
    send_frame(8'hA5, 1'b0, 1'b1, 6, 2500);
    send_pkt(vecs[0]);
    drain("timeout");

    // Resync: byte0 without bit 3 is dropped
    send_good(8'h00);
    send_pkt(vecs[2]);
    drain("resync");

    // rx_en dropped mid-frame: no pulses, and disarmed afterwards
    send_frame(8'h09, 1'b0, 1'b1, 5, 0);
    rx_en = 1'b0;
    #500 rx_en = 1'b1;
    #200;
    drain("rx_en_drop");
    send_good(8'h09);
    send_good(8'h05);
    send_good(8'hFB);
    drain("disarmed");
    send_ack();
    send_pkt(vecs[0]);
    drain("rearm");

    // Reset mid-packet
    send_good(8'h09);
    send_frame(8'h05, 1'b0, 1'b1, 4, 0);
    drain("pre_reset");
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    #100 reset = 1'b1;
    #200;
    send_ack();
    send_pkt(vecs[1]);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
